// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller: sequences fetch, decode, execute, multiply wait,
// memory access and write-back for the RV64 subset datapath.
module multicycle_ctrl #(
  parameter int MUL_LAT = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [6:0] opcode_i,
  input  logic [6:0] funct7_i,
  input  logic       alu_zero_i,
  input  logic       imem_ack_i,
  input  logic       dmem_ack_i,
  output logic       imem_req_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic       pc_src_o,
  output logic       alu_src_o,
  output logic [1:0] alu_op_o,
  output logic       mul_start_o,
  output logic       dmem_req_o,
  output logic       dmem_we_o,
  output logic       memtoreg_o,
  output logic       reg_we_o,
  output logic       illegal_o,
  output logic       busy_o,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MULW   = 3'd4;
  localparam logic [2:0] S_MEM    = 3'd5;
  localparam logic [2:0] S_WB     = 3'd6;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

  logic [2:0] state, state_nx;
  logic [3:0] cnt, cnt_nx;

  logic is_r, is_addi, is_ld, is_sd, is_beq, is_mul, legal;
  assign is_r    = (opcode_i == OP_R);
  assign is_addi = (opcode_i == OP_ADDI);
  assign is_ld   = (opcode_i == OP_LD);
  assign is_sd   = (opcode_i == OP_SD);
  assign is_beq  = (opcode_i == OP_BEQ);
  assign is_mul  = is_r && (funct7_i == F7_MUL);
  assign legal   = is_r | is_addi | is_ld | is_sd | is_beq;

  // Every path back to FETCH is an instruction boundary where start_i may park us.
  logic [2:0] bnd;
  assign bnd = start_i ? S_FETCH : S_IDLE;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE:   if (start_i) state_nx = S_FETCH;
      S_FETCH:  if (imem_ack_i) state_nx = S_DECODE;
      S_DECODE: state_nx = legal ? S_EXEC : bnd;
      S_EXEC: begin
        if (is_beq) state_nx = bnd;
        else if (is_mul) begin
          state_nx = S_MULW;
          cnt_nx   = MUL_LOAD;
        end
        else if (is_ld || is_sd) state_nx = S_MEM;
        else state_nx = S_WB;
      end
      S_MULW: begin
        if (cnt == 4'd0) state_nx = S_WB;
        else cnt_nx = cnt - 4'd1;
      end
      S_MEM:    if (dmem_ack_i) state_nx = is_sd ? bnd : S_WB;
      S_WB:     state_nx = bnd;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  logic alu_active;
  assign alu_active = (state == S_EXEC) || (state == S_MEM) || (state == S_WB);

  always_comb begin
    imem_req_o  = 1'b0;
    ir_we_o     = 1'b0;
    pc_we_o     = 1'b0;
    pc_src_o    = 1'b0;
    alu_src_o   = 1'b0;
    alu_op_o    = 2'b00;
    mul_start_o = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    memtoreg_o  = 1'b0;
    reg_we_o    = 1'b0;
    illegal_o   = 1'b0;
    if (alu_active) begin
      alu_src_o = is_addi | is_ld | is_sd;
      if (is_r)         alu_op_o = 2'b10;
      else if (is_addi) alu_op_o = 2'b11;
      else if (is_beq)  alu_op_o = 2'b01;
      else              alu_op_o = 2'b00;
    end
    case (state)
      S_FETCH: begin
        imem_req_o = 1'b1;
        ir_we_o    = imem_ack_i;
        pc_we_o    = imem_ack_i;
      end
      S_DECODE: illegal_o = ~legal;
      S_EXEC: begin
        if (is_beq) begin
          pc_we_o  = alu_zero_i;
          pc_src_o = 1'b1;
        end
        mul_start_o = is_mul;
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_sd;
      end
      S_WB: begin
        reg_we_o   = 1'b1;
        memtoreg_o = is_ld;
      end
      default: ;
    endcase
  end

  assign busy_o  = (state != S_IDLE);
  assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench: each instruction is expanded into its expected per-cycle
// trace (inputs + outputs) and replayed against the controller.
module tb_multicycle_ctrl;
  localparam int LAT = 4;

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [6:0] opc = '0, f7 = '0;
  logic       zero = 1'b0, iack = 1'b0, dack = 1'b0;
  logic       imem_req, ir_we, pc_we, pc_src, alu_src, mul_start;
  logic       dmem_req, dmem_we, memtoreg, reg_we, illegal, busy;
  logic [1:0] alu_op;
  logic [2:0] state;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MUL_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .opcode_i(opc), .funct7_i(f7),
    .alu_zero_i(zero), .imem_ack_i(iack), .dmem_ack_i(dack),
    .imem_req_o(imem_req), .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_src_o(pc_src),
    .alu_src_o(alu_src), .alu_op_o(alu_op), .mul_start_o(mul_start),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .memtoreg_o(memtoreg),
    .reg_we_o(reg_we), .illegal_o(illegal), .busy_o(busy), .state_o(state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic imem_req, ir_we, pc_we, pc_src, alu_src;
    logic [1:0] alu_op;
    logic mul_start, dmem_req, dmem_we, memtoreg, reg_we, illegal, busy;
  } out_t;
  typedef struct packed {logic ia, da, z, st;} in_t;
  typedef struct packed {logic [6:0] opc, f7; in_t i; out_t o;} step_t;
  typedef enum int {K_R, K_MUL, K_ADDI, K_LD, K_SD, K_BEQ, K_ILL} kind_t;

  out_t got;
  assign got = {state, imem_req, ir_we, pc_we, pc_src, alu_src, alu_op, mul_start,
                dmem_req, dmem_we, memtoreg, reg_we, illegal, busy};

  step_t      q[$];
  int         checks = 0, errors = 0, ncyc = 0;
  bit         idle_now = 1'b1;
  logic [6:0] cur_opc, cur_f7;

  task automatic chk(input string tag, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, g, e);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom % 2);
  endfunction

  function automatic out_t mk(input logic [2:0] st);
    out_t o = '0;
    o.st   = st;
    o.busy = (st != 3'd0);
    return o;
  endfunction

  function automatic out_t alu(input out_t o, input kind_t k);
    out_t r = o;
    r.alu_src = (k == K_ADDI) || (k == K_LD) || (k == K_SD);
    case (k)
      K_R, K_MUL: r.alu_op = 2'b10;
      K_ADDI:     r.alu_op = 2'b11;
      K_BEQ:      r.alu_op = 2'b01;
      default:    r.alu_op = 2'b00;
    endcase
    return r;
  endfunction

  task automatic push(input logic ia, input logic da, input logic z, input logic st, input out_t o);
    step_t s;
    s.opc = cur_opc; s.f7 = cur_f7;
    s.i = '{ia: ia, da: da, z: z, st: st};
    s.o = o;
    q.push_back(s);
  endtask

  // last_start: 0/1 forces start_i at the final cycle, 2 picks it at random
  task automatic plan(input kind_t k, input int fd, input int md, input int last_start);
    out_t o;
    logic z, ls;
    case (k)
      K_R, K_MUL: cur_opc = 7'b0110011;
      K_ADDI:     cur_opc = 7'b0010011;
      K_LD:       cur_opc = 7'b0000011;
      K_SD:       cur_opc = 7'b0100011;
      K_BEQ:      cur_opc = 7'b1100011;
      default: begin
        cur_opc = 7'($urandom);
        while (cur_opc inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011})
          cur_opc = 7'($urandom);
      end
    endcase
    cur_f7 = 7'($urandom);
    if (k == K_MUL) cur_f7 = 7'b0000001;
    else if (k == K_R) while (cur_f7 == 7'b0000001) cur_f7 = 7'($urandom);
    ls = (last_start == 2) ? ($urandom % 4 != 0) : last_start[0];

    if (idle_now) push(rb(), rb(), rb(), 1'b1, mk(3'd0));
    idle_now = 1'b0;
    for (int n = 0; n < fd; n++) begin
      o = mk(3'd1); o.imem_req = 1'b1;
      push(1'b0, rb(), rb(), rb(), o);
    end
    o = mk(3'd1); o.imem_req = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1;
    push(1'b1, rb(), rb(), rb(), o);
    o = mk(3'd2); o.illegal = (k == K_ILL);
    push(rb(), rb(), rb(), (k == K_ILL) ? ls : rb(), o);
    if (k != K_ILL) begin
      z = rb();
      o = alu(mk(3'd3), k);
      if (k == K_BEQ) begin o.pc_we = z; o.pc_src = 1'b1; end
      o.mul_start = (k == K_MUL);
      push(rb(), rb(), z, (k == K_BEQ) ? ls : rb(), o);
      if (k == K_MUL) repeat (LAT) push(rb(), rb(), rb(), rb(), mk(3'd4));
      if (k == K_LD || k == K_SD) begin
        o = alu(mk(3'd5), k); o.dmem_req = 1'b1; o.dmem_we = (k == K_SD);
        for (int n = 0; n < md; n++) push(rb(), 1'b0, rb(), rb(), o);
        push(rb(), 1'b1, rb(), (k == K_SD) ? ls : rb(), o);
      end
      if (k != K_BEQ && k != K_SD) begin
        o = alu(mk(3'd6), k); o.reg_we = 1'b1; o.memtoreg = (k == K_LD);
        push(rb(), rb(), rb(), ls, o);
      end
    end
    if (!ls) begin
      idle_now = 1'b1;
      repeat ($urandom % 3) push(rb(), rb(), rb(), 1'b0, mk(3'd0));
    end
  endtask

  task automatic drive(input step_t s);
    opc = s.opc; f7 = s.f7;
    iack = s.i.ia; dack = s.i.da; zero = s.i.z; start = s.i.st;
  endtask

  task automatic play(input int n);
    for (int k = 0; k < n && q.size() > 0; k++) begin
      step_t s = q.pop_front();
      @(negedge clk);
      drive(s);
      #1 chk($sformatf("cyc%0d exp_state%0d", ncyc, s.o.st), 32'(got), 32'(s.o));
      ncyc++;
    end
  endtask

  // Play n planned cycles, then assert reset during the next planned cycle.
  task automatic reset_mid(input int n);
    step_t s;
    play(n);
    s = q.pop_front();
    @(negedge clk);
    drive(s); rst = 1'b1;
    #1 chk($sformatf("rst_cycle exp_state%0d", s.o.st), 32'(got), 32'(s.o));
    @(negedge clk);
    rst = 1'b0; start = 1'b0; iack = 1'b1; dack = 1'b1;
    #1 chk("rst_then_idle", 32'(got), 32'(mk(3'd0)));
    q.delete();
    idle_now = 1'b1;
  endtask

  initial begin
    int pre;
    rst = 1'b1; start = 1'b0;
    repeat (2) begin
      @(negedge clk); #1 chk("reset", 32'(got), 32'(mk(3'd0)));
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk); iack = 1'b1; dack = 1'b1;
      #1 chk("idle", 32'(got), 32'(mk(3'd0)));
    end

    plan(K_ADDI, 0, 0, 1);
    plan(K_LD, 0, 3, 1);
    plan(K_BEQ, 0, 0, 1);
    plan(K_BEQ, 1, 0, 1);
    plan(K_MUL, 0, 0, 1);
    plan(K_ILL, 0, 0, 1);
    plan(K_SD, 2, 1, 1);
    plan(K_R, 0, 0, 1);
    plan(K_LD, 1, 0, 0);
    play(q.size());

    pre = idle_now ? 1 : 0;
    plan(K_SD, 0, 4, 1);
    reset_mid(pre + 3 + 2);
    pre = idle_now ? 1 : 0;
    plan(K_MUL, 0, 0, 1);
    reset_mid(pre + 3 + 2);

    repeat (300) begin
      plan(kind_t'($urandom % 7), int'($urandom % 4), int'($urandom % 4), 2);
      play(q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
